// File: rtl/count_enable_gen_pkg.sv
// rtl/count_enable_gen_pkg.sv - shared types and sizing helpers for the count-enable generator
package count_enable_gen_pkg;

    // Button-mode strobe FSM: waiting for a press, holding before auto-repeat, auto-repeating
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Width of a counter that must reach max_val-1; never narrower than one bit
    function automatic int cnt_width(input int max_val);
        if (max_val <= 2) begin
            return 1;
        end
        return $clog2(max_val);
    endfunction

    // Larger of two integers, used to size the shared hold/repeat counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/count_enable_gen_debounce_sync.sv
// rtl/count_enable_gen_debounce_sync.sv - button synchroniser, polarity fix and debounce filter
module count_enable_gen_debounce_sync
    import count_enable_gen_pkg::*;
#(
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise
);

    localparam int   DB_W      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic RAW_IDLE  = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            lvl_q;
    logic            lvl_d;
    logic            db_q;
    logic            db_d;
    logic            rise_q;
    logic            rise_d;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    // Normalise polarity so that 1 always means pressed, and run the stability counter.
    // A mismatch must persist for DEBOUNCE_CYCLES consecutive cycles; any agreement
    // with the current debounced level restarts the count from zero.
    always_comb begin
        lvl_d  = (BTN_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
        db_d   = db_q;
        rise_d = 1'b0;
        cnt_d  = cnt_q;
        if (lvl_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_TERM) begin
            db_d   = ~db_q;
            rise_d = ~db_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Two-flop synchroniser loads the not-pressed pin level on reset so no false press appears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RAW_IDLE;
            sync2_q <= RAW_IDLE;
            lvl_q   <= 1'b0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db   = db_q;
    assign btn_rise = rise_q;

endmodule

// File: rtl/count_enable_gen.sv
// rtl/count_enable_gen.sv - single-cycle count strobe from debounced button or divided tick
module count_enable_gen
    import count_enable_gen_pkg::*;
#(
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int TICK_DIV        = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic auto_mode,
    output logic enable,
    output logic btn_db,
    output logic repeating
);

    localparam int HOLD_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam int TICK_W = cnt_width(TICK_DIV);
    localparam logic [HOLD_W-1:0] DELAY_TERM  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_TERM = HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [TICK_W-1:0] TICK_TERM   = TICK_W'(TICK_DIV - 1);

    logic              db_level;
    logic              db_rise;

    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic [TICK_W-1:0] div_q;
    logic [TICK_W-1:0] div_d;
    logic              enable_q;
    logic              enable_d;
    logic              repeating_q;
    logic              repeating_d;
    logic              btn_pulse;
    logic              tick_pulse;

    count_enable_gen_debounce_sync #(
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_db   (db_level),
        .btn_rise (db_rise)
    );

    // Free-running divider; parked at zero outside auto mode so the first tick
    // lands a full TICK_DIV cycles after auto mode is entered
    always_comb begin
        div_d      = '0;
        tick_pulse = 1'b0;
        if (auto_mode) begin
            if (div_q == TICK_TERM) begin
                tick_pulse = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Button FSM next state: the hold counter is shared by HOLD and REPEAT and is
    // cleared on every transition; a release seen together with a terminal count
    // takes priority and suppresses the strobe
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        btn_pulse = 1'b0;
        if (auto_mode) begin
            state_d = IDLE;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    hold_d = '0;
                    if (db_rise) begin
                        btn_pulse = 1'b1;
                        state_d   = HOLD;
                    end
                end
                HOLD: begin
                    if (!db_level) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else if (hold_q == DELAY_TERM) begin
                        btn_pulse = 1'b1;
                        state_d   = REPEAT;
                        hold_d    = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!db_level) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else if (hold_q == PERIOD_TERM) begin
                        btn_pulse = 1'b1;
                        hold_d    = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // Output mux; a strobe directly following another is dropped so the counter
    // never sees enable high on two consecutive cycles across a mode switch
    always_comb begin
        enable_d    = (btn_pulse | tick_pulse) & ~enable_q;
        repeating_d = (state_d == REPEAT);
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            div_q       <= '0;
            enable_q    <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            div_q       <= div_d;
            enable_q    <= enable_d;
            repeating_q <= repeating_d;
        end
    end

    assign enable    = enable_q;
    assign repeating = repeating_q;
    assign btn_db    = db_level;

endmodule

// File: tb/tb_count_enable_gen.sv
// tb/tb_count_enable_gen.sv - self-checking bench for count_enable_gen
module tb_count_enable_gen;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int TD  = 8;

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic btn_raw   = 1'b1;
    logic auto_mode = 1'b0;
    logic enable;
    logic btn_db;
    logic repeating;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit hist [64];
    bit m_db;
    bit m_db_prev;
    bit exp_en;
    bit exp_rep;
    int m_held;
    int m_auto_cnt;
    int edge_n = 100;

    count_enable_gen #(
        .BTN_ACTIVE_LOW  (1),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .TICK_DIV        (TD)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .btn_raw   (btn_raw),
        .auto_mode (auto_mode),
        .enable    (enable),
        .btn_db    (btn_db),
        .repeating (repeating)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) hist[i] = 1'b0;
        m_db       = 1'b0;
        m_db_prev  = 1'b0;
        exp_en     = 1'b0;
        exp_rep    = 1'b0;
        m_held     = -1;
        m_auto_cnt = 0;
    endfunction

    // Advance one clock edge, update the behavioural model, then settle past the edge.
    // Model rules: btn_db flips once the DEB pressed-level samples taken 3..DEB+2 edges
    // ago all disagree with it; strobes come one edge after a rise, then RD edges later,
    // then every RP edges while held; auto mode strobes every TD-th edge spent in it.
    task automatic step();
        bit en;
        bit rep;
        bit all_diff;
        int e;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            model_reset();
        end else begin
            en  = 1'b0;
            rep = 1'b0;
            if (auto_mode) begin
                m_held = -1;
                m_auto_cnt++;
                en = ((m_auto_cnt % TD) == 0);
            end else begin
                m_auto_cnt = 0;
                if (m_held >= 0) begin
                    if (!m_db) begin
                        m_held = -1;
                    end else begin
                        e   = edge_n - m_held;
                        en  = (e == RD) || (e > RD && ((e - RD) % RP) == 0);
                        rep = (e >= RD);
                    end
                end else if (m_db && !m_db_prev) begin
                    en     = 1'b1;
                    m_held = edge_n;
                end
            end
            exp_en  = en && !exp_en;
            exp_rep = rep;
            hist[edge_n[5:0]] = ~btn_raw;
            all_diff = 1'b1;
            for (int j = edge_n - 2 - DEB; j <= edge_n - 3; j++) begin
                if (hist[j[5:0]] == m_db) all_diff = 1'b0;
            end
            m_db_prev = m_db;
            if (all_diff) m_db = ~m_db;
        end
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({enable, repeating, btn_db} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async: en/rep/db got %b%b%b want 000", enable, repeating, btn_db);
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL reset_hold edge %0d: got %b%b%b want %b%b%b", edge_n,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL reset_idle edge %0d: got %b%b%b want %b%b%b", edge_n,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
        end
    endtask

    task automatic test_clean_press();
        int e0;
        int rel;
        int n_after;
        logic want;
        btn_raw = 1'b0;
        e0 = edge_n + 1;
        for (int i = 0; i < 60; i++) begin
            step();
            rel = edge_n - e0;
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL clean_press_model rel %0d: got %b%b%b want %b%b%b", rel,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
            if (rel == 5 || rel == 6) begin
                want = (rel == 6);
                checks++;
                if (btn_db !== want) begin
                    errors++;
                    $display("FAIL clean_press_db rel %0d: got %b want %b", rel, btn_db, want);
                end
            end
            if (rel inside {6, 7, 8, 26, 27, 31, 32, 37}) begin
                want = (rel inside {7, 27, 32, 37});
                checks++;
                if (enable !== want) begin
                    errors++;
                    $display("FAIL clean_press_en rel %0d: got %b want %b", rel, enable, want);
                end
            end
            if (rel == 26 || rel == 27) begin
                want = (rel == 27);
                checks++;
                if (repeating !== want) begin
                    errors++;
                    $display("FAIL clean_press_rep rel %0d: got %b want %b", rel, repeating, want);
                end
            end
        end
        btn_raw = 1'b1;
        n_after = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL clean_release_model edge %0d: got %b%b%b want %b%b%b", edge_n,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
            if (i >= 8 && enable) n_after++;
        end
        checks++;
        if (n_after != 0 || repeating !== 1'b0) begin
            errors++;
            $display("FAIL clean_release_idle: enables %0d rep %b want 0 0", n_after, repeating);
        end
    endtask

    task automatic test_bounce();
        int n_bounce;
        int n_settle;
        int e_end;
        int rel;
        n_bounce = 0;
        for (int i = 0; i < 20; i++) begin
            btn_raw = ((i / 2) % 2) != 0;
            step();
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL bounce_model edge %0d: got %b%b%b want %b%b%b", edge_n,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
            if (enable) n_bounce++;
        end
        btn_raw  = 1'b0;
        e_end    = edge_n + 1;
        n_settle = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            rel = edge_n - e_end;
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL bounce_settle_model rel %0d: got %b%b%b want %b%b%b", rel,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
            if (enable) begin
                n_settle++;
                checks++;
                if (rel != DEB + 3) begin
                    errors++;
                    $display("FAIL bounce_latency: strobe at rel %0d want %0d", rel, DEB + 3);
                end
            end
        end
        checks++;
        if (n_bounce != 0 || n_settle != 1) begin
            errors++;
            $display("FAIL bounce_count: during %0d after %0d want 0 1", n_bounce, n_settle);
        end
        btn_raw = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL bounce_release edge %0d: got %b%b%b want %b%b%b", edge_n,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
        end
    endtask

    task automatic test_short_tap();
        int n_en;
        n_en = 0;
        btn_raw = 1'b0;
        for (int rel = 0; rel < 40; rel++) begin
            if (rel == 10) btn_raw = 1'b1;
            step();
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL short_tap_model rel %0d: got %b%b%b want %b%b%b", rel,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
            if (enable) n_en++;
            if (rel == 15 || rel == 16) begin
                checks++;
                if (btn_db !== (rel == 15)) begin
                    errors++;
                    $display("FAIL short_tap_db rel %0d: got %b want %b", rel, btn_db, rel == 15);
                end
            end
        end
        checks++;
        if (n_en != 1) begin
            errors++;
            $display("FAIL short_tap_count: got %0d strobes want 1", n_en);
        end
    endtask

    task automatic test_auto_mode();
        int e0;
        int rel;
        int n_post;
        auto_mode = 1'b1;
        e0 = edge_n;
        for (int i = 1; i <= 40; i++) begin
            if (i == 10) btn_raw = 1'b0;
            if (i == 25) btn_raw = 1'b1;
            if (i == 30) btn_raw = 1'b0;
            step();
            rel = edge_n - e0;
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL auto_model rel %0d: got %b%b%b want %b%b%b", rel,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
            checks++;
            if (enable !== ((rel % TD) == 0)) begin
                errors++;
                $display("FAIL auto_tick rel %0d: got %b want %b", rel, enable, (rel % TD) == 0);
            end
        end
        auto_mode = 1'b0;
        n_post = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL auto_exit_model edge %0d: got %b%b%b want %b%b%b", edge_n,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
            if (enable) n_post++;
        end
        checks++;
        if (n_post != 0 || btn_db !== 1'b1) begin
            errors++;
            $display("FAIL auto_exit_held: strobes %0d db %b want 0 1", n_post, btn_db);
        end
        btn_raw = 1'b1;
        for (int i = 0; i < 12; i++) step();
        checks++;
        if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
            errors++;
            $display("FAIL auto_release: got %b%b%b want %b%b%b",
                     enable, repeating, btn_db, exp_en, exp_rep, m_db);
        end
    endtask

    task automatic test_reset_mid_repeat();
        bit found;
        int e0;
        int n_en;
        found = 1'b0;
        btn_raw = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL rst_mid_model edge %0d: got %b%b%b want %b%b%b", edge_n,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
            if (repeating) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_mid_reach_repeat: repeating got 0 want 1 within 40 cycles");
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({enable, repeating, btn_db} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_async: en/rep/db got %b%b%b want 000", enable, repeating, btn_db);
        end
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        e0 = edge_n + 1;
        n_en = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL rst_mid_after edge %0d: got %b%b%b want %b%b%b", edge_n,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
            if (enable) begin
                n_en++;
                checks++;
                if (edge_n - e0 != DEB + 3) begin
                    errors++;
                    $display("FAIL rst_mid_latency: strobe at rel %0d want %0d", edge_n - e0, DEB + 3);
                end
            end
        end
        checks++;
        if (n_en != 1) begin
            errors++;
            $display("FAIL rst_mid_count: got %0d strobes want 1", n_en);
        end
        btn_raw = 1'b1;
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_release_at_terminal();
        btn_raw = 1'b0;
        for (int rel = 0; rel < 50; rel++) begin
            if (rel == 35) btn_raw = 1'b1;
            step();
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL rel_term_model rel %0d: got %b%b%b want %b%b%b", rel,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
            if (rel == 37 || rel == 41) begin
                checks++;
                if ({enable, repeating} !== {rel == 37, 1'b1}) begin
                    errors++;
                    $display("FAIL rel_term_pre rel %0d: en/rep got %b%b want %b1", rel,
                             enable, repeating, rel == 37);
                end
            end
            if (rel == 42) begin
                checks++;
                if ({enable, repeating, btn_db} !== 3'b000) begin
                    errors++;
                    $display("FAIL rel_term_coincide: en/rep/db got %b%b%b want 000",
                             enable, repeating, btn_db);
                end
            end
        end
    endtask

    task automatic test_random();
        int  hold_left;
        bit  prev_en;
        hold_left = 0;
        prev_en   = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (hold_left == 0) begin
                btn_raw   = 1'($urandom_range(0, 1));
                hold_left = $urandom_range(1, 30);
                if ($urandom_range(0, 9) == 0) auto_mode = ~auto_mode;
            end
            hold_left--;
            step();
            checks++;
            if ({enable, repeating, btn_db} !== {exp_en, exp_rep, m_db}) begin
                errors++;
                $display("FAIL random_model edge %0d: got %b%b%b want %b%b%b", edge_n,
                         enable, repeating, btn_db, exp_en, exp_rep, m_db);
            end
            checks++;
            if (enable && prev_en) begin
                errors++;
                $display("FAIL random_back_to_back edge %0d: enable got 1 want 0", edge_n);
            end
            prev_en = enable;
        end
        auto_mode = 1'b0;
        btn_raw   = 1'b1;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if ({enable, repeating, btn_db} !== 3'b000) begin
            errors++;
            $display("FAIL random_quiesce: got %b%b%b want 000", enable, repeating, btn_db);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_tap();
        test_auto_mode();
        test_reset_mid_repeat();
        test_release_at_terminal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
